branch_cmp_arbiter: RTL and testbench

Shares a single branch comparator between `NREQ` requesters (e.g. two issue slots or harts) using round-robin arbitration and valid/ready handshakes. Each request carries two operands and a RISC-V branch `func3`. The granted request is compared and its result is registered into a single response channel, one cycle after acceptance. The block sits between the issue/decode stages and the branch-resolution logic of the core.

---
 rtl/cmp_pkg.sv | 19 +
 rtl/branch_cmp.sv | 30 +++
 rtl/branch_cmp_arbiter.sv | 114 +++++++++++
 tb/tb_branch_cmp_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared constants for the branch comparator and its arbiter wrapper.
package cmp_pkg;

  localparam int XLEN_DEFAULT = 32;

  // RISC-V conditional-branch func3 encodings.
  localparam logic [2:0] F3_EQ  = 3'b000;
  localparam logic [2:0] F3_NE  = 3'b001;
  localparam logic [2:0] F3_LT  = 3'b100;
  localparam logic [2:0] F3_GE  = 3'b101;
  localparam logic [2:0] F3_LTU = 3'b110;
  localparam logic [2:0] F3_GEU = 3'b111;

  // 010 and 011 carry no branch meaning.
  function automatic logic is_reserved(input logic [2:0] func3);
    return (func3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Purely combinational branch comparator: (rs1, rs2, func3) -> (taken, illegal).
module branch_cmp
  import cmp_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      func3,
  output logic            taken,
  output logic            illegal
);

  // Evaluate the selected condition; reserved codes never branch.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of inferred latches.
    taken   = 1'b0;
    illegal = 1'b0;
    case (func3)
      F3_EQ:   taken = (rs1 == rs2);
      F3_NE:   taken = (rs1 != rs2);
      F3_LT:   taken = ($signed(rs1) <  $signed(rs2));
      F3_GE:   taken = ($signed(rs1) >= $signed(rs2));
      F3_LTU:  taken = (rs1 <  rs2);
      F3_GEU:  taken = (rs1 >= rs2);
      default: illegal = is_reserved(func3);
    endcase
  end

endmodule

// File: rtl/branch_cmp_arbiter.sv
// Round-robin sharing of one branch comparator between NREQ requesters,
// with a single registered response channel.
module branch_cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = XLEN_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_rs1,
  input  logic [NREQ*XLEN-1:0] req_rs2,
  input  logic [NREQ*3-1:0]    req_func3,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic               resp_taken,
  output logic               resp_illegal
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  grant;
  logic            any_valid;
  logic            can_accept;
  logic            accept;
  logic [XLEN-1:0] rs1_sel, rs2_sel;
  logic [2:0]      func3_sel;
  logic            cmp_taken, cmp_illegal;

  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic            resp_taken_q, resp_taken_d;
  logic            resp_illegal_q, resp_illegal_d;

  // Scan from ptr upward with wrap; scanning downward lets the closest hit win.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NREQ]) begin
        grant     = IDW'((int'(ptr_q) + k) % NREQ);
        any_valid = 1'b1;
      end
    end
  end

  assign can_accept = !resp_valid_q || resp_ready;
  assign accept     = any_valid && can_accept && !rst;

  // One-hot ready on the granted requester only; depends on valids, never on payload.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
    end
  end

  assign rs1_sel   = req_rs1[int'(grant)*XLEN +: XLEN];
  assign rs2_sel   = req_rs2[int'(grant)*XLEN +: XLEN];
  assign func3_sel = req_func3[int'(grant)*3 +: 3];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1     (rs1_sel),
    .rs2     (rs2_sel),
    .func3   (func3_sel),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  // Next state of the response register and round-robin pointer.
  always_comb begin
    resp_valid_d   = resp_valid_q;
    resp_id_d      = resp_id_q;
    resp_taken_d   = resp_taken_q;
    resp_illegal_d = resp_illegal_q;
    ptr_d          = ptr_q;
    if (accept) begin
      resp_valid_d   = 1'b1;
      resp_id_d      = grant;
      resp_taken_d   = cmp_taken;
      resp_illegal_d = cmp_illegal;
      ptr_d          = IDW'((int'(grant) + 1) % NREQ);
    end else if (resp_ready) begin
      resp_valid_d   = 1'b0;
    end
  end

  // State registers with synchronous reset; a pending result is dropped on reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (rst) begin
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_taken_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      ptr_q          <= '0;
    end else begin
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_taken_q   <= resp_taken_d;
      resp_illegal_q <= resp_illegal_d;
      ptr_q          <= ptr_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_taken   = resp_taken_q;
  assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_branch_cmp_arbiter.sv
// Self-checking bench for branch_cmp_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_branch_cmp_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int IDW  = 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_rs1 = '0;
  logic [NREQ*XLEN-1:0] req_rs2 = '0;
  logic [NREQ*3-1:0]    req_func3 = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b1;
  logic [IDW-1:0]       resp_id;
  logic                 resp_taken;
  logic                 resp_illegal;

  branch_cmp_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_func3    (req_func3),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_taken   (resp_taken),
    .resp_illegal (resp_illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Requester side: a pending request per requester, held until accepted.
  logic            pend  [NREQ];
  logic [XLEN-1:0] p_rs1 [NREQ];
  logic [XLEN-1:0] p_rs2 [NREQ];
  logic [2:0]      p_f3  [NREQ];

  // Reference model state.
  bit m_valid;
  int m_id;
  bit m_taken;
  bit m_illegal;
  int m_ptr;

  int              last_acc;
  logic [NREQ-1:0] obs_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Branch semantics straight from the ISA definition.
  task automatic ref_cmp(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [2:0] f3, output bit tk, output bit il);
    tk = 1'b0;
    il = 1'b0;
    case (f3)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = ($signed(a) < $signed(b));
      3'd5: tk = ($signed(a) >= $signed(b));
      3'd6: tk = (a < b);
      3'd7: tk = (a >= b);
      default: il = 1'b1;
    endcase
  endtask

  task automatic present(input int i, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [2:0] f3);
    pend[i]  = 1'b1;
    p_rs1[i] = a;
    p_rs2[i] = b;
    p_f3[i]  = f3;
  endtask

  // One clock cycle: drive, check combinational and registered outputs
  // against the model, advance the model, then cross the rising edge.
  task automatic step(input logic r, input logic rr);
    int              g;
    bit              can;
    bit              tk, il;
    logic [NREQ-1:0] exp_ready;
    rst        = r;
    resp_ready = rr;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = pend[i];
      req_rs1[i*XLEN +: XLEN]   = p_rs1[i];
      req_rs2[i*XLEN +: XLEN]   = p_rs2[i];
      req_func3[i*3 +: 3]       = p_f3[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      if (g < 0 && pend[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    end
    can       = !m_valid || rr;
    exp_ready = '0;
    if (!r && can && g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;
    check("req_ready",    32'(req_ready),    32'(exp_ready));
    check("resp_valid",   32'(resp_valid),   32'(m_valid));
    if (m_valid) begin
      check("resp_id",      32'(resp_id),      32'(m_id));
      check("resp_taken",   32'(resp_taken),   32'(m_taken));
      check("resp_illegal", 32'(resp_illegal), 32'(m_illegal));
    end
    last_acc = -1;
    if (r) begin
      m_valid = 0; m_id = 0; m_taken = 0; m_illegal = 0; m_ptr = 0;
    end else if (exp_ready != '0) begin
      ref_cmp(p_rs1[g], p_rs2[g], p_f3[g], tk, il);
      m_valid = 1; m_id = g; m_taken = tk; m_illegal = il;
      m_ptr = (g + 1) % NREQ;
      last_acc = g;
    end else if (rr) begin
      m_valid = 0;
    end
    @(posedge clk);
    if (last_acc >= 0) pend[last_acc] = 1'b0;
    @(negedge clk);
  endtask

  logic [XLEN-1:0] pool [6];
  logic            held_id, held_taken, held_illegal;
  int              first_id;

  initial begin
    pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
    pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h0000_0001; pool[5] = 32'h0000_0005;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_rs1[i] = '0; p_rs2[i] = '0; p_f3[i] = '0;
    end
    m_valid = 0; m_id = 0; m_taken = 0; m_illegal = 0; m_ptr = 0;

    // Bring the DUT out of the unknown power-up state.
    @(posedge clk);
    @(negedge clk);

    // Reset held 3 cycles with both requesters valid: nothing accepted.
    present(0, 32'd3, 32'd3, 3'b000);
    present(1, 32'd4, 32'd3, 3'b001);
    repeat (3) step(1'b1, 1'b1);
    check("rst_reg_valid", 32'(resp_valid), 32'd0);
    check("rst_reg_id",    32'(resp_id),    32'd0);
    // First grant after release goes to requester 0.
    step(1'b0, 1'b1);
    check("first_grant", 32'(obs_ready), 32'd1);
    step(1'b0, 1'b1);
    check("second_grant", 32'(obs_ready), 32'd2);
    step(1'b0, 1'b1);

    // Single request latency: signed LT then unsigned LTU on the same operands.
    present(0, 32'hFFFF_FFFF, 32'd1, 3'b100);
    step(1'b0, 1'b1);
    check("lat_valid", 32'(resp_valid), 32'd1);
    check("lat_id",    32'(resp_id),    32'd0);
    check("lat_lt",    32'(resp_taken), 32'd1);
    present(0, 32'hFFFF_FFFF, 32'd1, 3'b110);
    step(1'b0, 1'b1);
    check("lat_ltu", 32'(resp_taken), 32'd0);
    step(1'b0, 1'b1);

    // Round-robin with both always valid: ids alternate, no gaps.
    first_id = m_ptr;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) present(i, 32'(k), 32'(i), 3'b000);
      step(1'b0, 1'b1);
      check("rr_valid", 32'(resp_valid), 32'd1);
      check("rr_id",    32'(resp_id),    32'((first_id + k) % NREQ));
    end

    // Backpressure: result pending, consumer stalled 4 cycles.
    for (int i = 0; i < NREQ; i++) if (!pend[i]) present(i, 32'd9, 32'd2, 3'b111);
    held_id = resp_id; held_taken = resp_taken; held_illegal = resp_illegal;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0);
      check("bp_hold_valid", 32'(resp_valid), 32'd1);
      check("bp_hold_id",    32'(resp_id),    32'(held_id));
      check("bp_hold_taken", 32'(resp_taken), 32'(held_taken));
      check("bp_hold_ill",   32'(resp_illegal), 32'(held_illegal));
    end
    step(1'b0, 1'b1);
    check("bp_release_accept", 32'($countones(obs_ready)), 32'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Reserved func3.
    present(0, 32'd5, 32'd5, 3'b010);
    step(1'b0, 1'b1);
    check("ill_flag",  32'(resp_illegal), 32'd1);
    check("ill_taken", 32'(resp_taken),   32'd0);

    // Equality codes on the sign-bit pattern.
    present(1, 32'h8000_0000, 32'h8000_0000, 3'b000);
    step(1'b0, 1'b1);
    check("eq_taken", 32'(resp_taken), 32'd1);
    present(1, 32'h8000_0000, 32'h8000_0000, 3'b001);
    step(1'b0, 1'b1);
    check("ne_taken", 32'(resp_taken), 32'd0);

    // Reset mid-operation drops a pending result.
    present(0, 32'd1, 32'd2, 3'b100);
    present(1, 32'd1, 32'd2, 3'b100);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("midrst_valid", 32'(resp_valid), 32'd0);

    // Randomized traffic with stalls, occasional resets and all func3 codes.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          present(i,
                  ($urandom_range(1, 0) == 1) ? pool[$urandom_range(5, 0)] : $urandom,
                  ($urandom_range(1, 0) == 1) ? pool[$urandom_range(5, 0)] : $urandom,
                  3'($urandom_range(7, 0)));
        end
      end
      step(($urandom_range(49, 0) == 0), ($urandom_range(3, 0) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
